// File: rtl/mem_access_ctrl.sv
// MEM-stage data RAM initiator: byte-lane stores, stalled loads with lane extraction and extension.
// Optional stall-cycle counter is enabled by defining MEM_STALL_COUNT_EN.
module mem_access_ctrl #(
   parameter int unsigned len           = 32,
   parameter int unsigned RAM_ADDR_BITS = 10,
   parameter int unsigned READ_LATENCY  = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_mem_read,
   input  logic                     i_mem_write,
   input  logic [1:0]               i_size,
   input  logic                     i_unsigned,
   input  logic [len-1:0]           i_address,
   input  logic [len-1:0]           i_write_data,
   output logic [len-1:0]           o_read_data,
   output logic                     o_stall,
   output logic                     o_misaligned,
   output logic [RAM_ADDR_BITS-1:0] o_ram_addr,
   output logic [len-1:0]           o_ram_din,
   output logic [3:0]               o_ram_we,
   output logic                     o_ram_en,
   output logic                     o_ram_regce,
   input  logic [len-1:0]           i_ram_dout,
   output logic [31:0]              o_stall_count
);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

   state_t                   state_q, state_d;
   logic [1:0]               cnt_q, cnt_d;
   logic [1:0]               lane_q, lane_d;
   logic [1:0]               size_q, size_d;
   logic                     uns_q, uns_d;
   logic [RAM_ADDR_BITS-1:0] waddr_q, waddr_d;
   logic [len-1:0]           rdata_q, rdata_d;

   logic                     is_half, is_word, misaligned;
   logic [len-1:0]           lane_data, ext_data;
   logic                     unused_addr;

   assign unused_addr = ^i_address[len-1:RAM_ADDR_BITS+2];

   assign is_half    = (i_size == 2'b01);
   assign is_word    = i_size[1];
   assign misaligned = (is_half & i_address[0]) | (is_word & (i_address[1:0] != 2'b00));

   // Shift the addressed lane down to bit 0, then extend according to the latched size.
   always_comb begin
      lane_data = i_ram_dout >> {lane_q, 3'b000};
      case (size_q)
         2'b00:   ext_data = uns_q ? {24'h0, lane_data[7:0]}
                                   : {{24{lane_data[7]}}, lane_data[7:0]};
         2'b01:   ext_data = uns_q ? {16'h0, lane_data[15:0]}
                                   : {{16{lane_data[15]}}, lane_data[15:0]};
         default: ext_data = lane_data;
      endcase
   end

   always_comb begin
      case (i_size)
         2'b00:   o_ram_din = {4{i_write_data[7:0]}};
         2'b01:   o_ram_din = {2{i_write_data[15:0]}};
         default: o_ram_din = i_write_data;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      lane_d       = lane_q;
      size_d       = size_q;
      uns_d        = uns_q;
      waddr_d      = waddr_q;
      rdata_d      = rdata_q;
      o_stall      = 1'b0;
      o_misaligned = 1'b0;
      o_ram_en     = 1'b0;
      o_ram_we     = 4'b0000;
      o_ram_regce  = 1'b0;
      o_ram_addr   = (state_q == IDLE) ? i_address[RAM_ADDR_BITS+1:2] : waddr_q;

      // Outputs are gated by reset so an aborted load drops the stall immediately.
      if (!i_rst) begin
         case (state_q)
            IDLE: begin
               if (i_mem_write) begin
                  if (misaligned) begin
                     o_misaligned = 1'b1;
                  end else begin
                     o_ram_en = 1'b1;
                     case (i_size)
                        2'b00:   o_ram_we = 4'b0001 << i_address[1:0];
                        2'b01:   o_ram_we = 4'b0011 << i_address[1:0];
                        default: o_ram_we = 4'b1111;
                     endcase
                  end
               end else if (i_mem_read) begin
                  if (misaligned) begin
                     o_misaligned = 1'b1;
                  end else begin
                     o_ram_en = 1'b1;
                     o_stall  = 1'b1;
                     lane_d   = i_address[1:0];
                     size_d   = i_size;
                     uns_d    = i_unsigned;
                     waddr_d  = i_address[RAM_ADDR_BITS+1:2];
                     cnt_d    = 2'(READ_LATENCY - 1);
                     state_d  = WAIT;
                  end
               end
            end
            WAIT: begin
               o_stall     = 1'b1;
               o_ram_regce = (READ_LATENCY == 2);
               if (cnt_q == 2'd0) begin
                  rdata_d = ext_data;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q - 2'd1;
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         lane_q  <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         waddr_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lane_q  <= lane_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         waddr_q <= waddr_d;
         rdata_q <= rdata_d;
      end
   end

   assign o_read_data = rdata_q;

`ifdef MEM_STALL_COUNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_q + 32'(o_stall);
   end

   assign o_stall_count = stall_cnt_q;
`else
   assign o_stall_count = '0;
`endif

endmodule
